// File: rtl/redmule_job_dispatcher.sv
// Job dispatcher for the RedMulE accelerator: queues job descriptors and
// programs the accelerator register file one job at a time.
//
// state | meaning
// IDLE  | waiting for a queued descriptor; zero-size jobs are dropped here
// PROG  | writing the five job registers, one write outstanding
// TRIG  | writing the trigger register
// BUSY  | accelerator running, waiting for its end-of-job event
// DONE  | completion pulse and counter update, then back to IDLE
module redmule_job_dispatcher #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [ADDR_W-1:0] job_x_i,
    input  logic [ADDR_W-1:0] job_w_i,
    input  logic [ADDR_W-1:0] job_z_i,
    input  logic [15:0]       job_m_i,
    input  logic [15:0]       job_n_i,
    input  logic [15:0]       job_k_i,
    output logic              cfg_req_o,
    input  logic              cfg_gnt_i,
    output logic [7:0]        cfg_addr_o,
    output logic [31:0]       cfg_wdata_o,
    input  logic              evt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       done_cnt_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] w;
        logic [ADDR_W-1:0] z;
        logic [15:0]       m;
        logic [15:0]       n;
        logic [15:0]       k;
    } job_t;

    typedef enum logic [2:0] {IDLE, PROG, TRIG, BUSY, DONE} state_t;

    job_t           queue_mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    job_t           head;
    job_t           incoming;
    job_t           cur;
    state_t         state;
    logic [2:0]     idx;
    logic [15:0]    done_cnt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign push        = job_valid_i && !full;
    assign head        = queue_mem[rd_ptr[PTR_W-1:0]];
    assign incoming    = {job_x_i, job_w_i, job_z_i, job_m_i, job_n_i, job_k_i};
    assign job_ready_o = !full;
    assign done_cnt_o  = done_cnt;

    // Register write sequence of a job: {byte offset, data}.
    function automatic logic [39:0] prog_word(input logic [2:0] sel, input job_t j);
        logic [39:0] word;
        case (sel)
            3'd0:    word = {8'h00, 32'(j.x)};
            3'd1:    word = {8'h04, 32'(j.w)};
            3'd2:    word = {8'h08, 32'(j.z)};
            3'd3:    word = {8'h0C, j.k, j.m};
            3'd4:    word = {8'h10, 16'h0000, j.n};
            default: word = {8'h20, 32'h0000_0001};
        endcase
        return word;
    endfunction

    // Descriptor storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            queue_mem[wr_ptr[PTR_W-1:0]] <= incoming;
        end
    end

    // Write pointer advances on every accepted push, in any FSM state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Job sequencer: pop, program, trigger, wait for the event, report.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            cur         <= '0;
            idx         <= '0;
            cfg_req_o   <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            done_cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur    <= head;
                        rd_ptr <= rd_ptr + PTR_ONE;
                        if (head.m == '0 || head.n == '0 || head.k == '0) begin
                            err_o <= 1'b1;
                        end else begin
                            state     <= PROG;
                            busy_o    <= 1'b1;
                            idx       <= 3'd0;
                            cfg_req_o <= 1'b1;
                            {cfg_addr_o, cfg_wdata_o} <= prog_word(3'd0, head);
                        end
                    end
                end
                PROG: begin
                    if (cfg_gnt_i) begin
                        if (idx == 3'd4) begin
                            state <= TRIG;
                        end
                        idx <= idx + 3'd1;
                        {cfg_addr_o, cfg_wdata_o} <= prog_word(idx + 3'd1, cur);
                    end
                end
                TRIG: begin
                    if (cfg_gnt_i) begin
                        state       <= BUSY;
                        cfg_req_o   <= 1'b0;
                        cfg_addr_o  <= '0;
                        cfg_wdata_o <= '0;
                    end
                end
                BUSY: begin
                    if (evt_i) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        done_cnt <= done_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_redmule_job_dispatcher.sv
// Self-checking bench for redmule_job_dispatcher: directed and randomized jobs
// compared against a job-level model of the expected register writes/events.
module tb_redmule_job_dispatcher;
    localparam int  DEPTH  = 4;
    localparam int  ADDR_W = 32;
    localparam byte EV_D   = 8'h44;
    localparam byte EV_E   = 8'h45;

    typedef struct {
        logic [31:0] x;
        logic [31:0] w;
        logic [31:0] z;
        logic [15:0] m;
        logic [15:0] n;
        logic [15:0] k;
    } job_s;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          hold;
    } wr_s;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_x = '0, job_w = '0, job_z = '0;
    logic [15:0] job_m = '0, job_n = '0, job_k = '0;
    logic        cfg_req;
    logic        cfg_gnt = 1'b0;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        evt = 1'b0;
    logic        busy, done, err;
    logic [15:0] done_cnt;

    redmule_job_dispatcher #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_x_i(job_x), .job_w_i(job_w), .job_z_i(job_z),
        .job_m_i(job_m), .job_n_i(job_n), .job_k_i(job_k),
        .cfg_req_o(cfg_req), .cfg_gnt_i(cfg_gnt),
        .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata),
        .evt_i(evt), .busy_o(busy), .done_o(done), .err_o(err),
        .done_cnt_o(done_cnt)
    );

    always #5 clk = ~clk;

    // Model and observation state
    logic [39:0] exp_w[$];
    byte         exp_ev[$];
    logic [15:0] exp_cnt = '0;
    wr_s         obs_w[$];
    byte         obs_ev[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, stab_viol = 0;
    int          first_req_cyc = -1, last_done_cyc = -1;
    int          trig_seen = 0, trig_handled = 0;
    // Environment knobs
    int          gnt_mode = 0, gnt_delay = 0, evt_delay = 0;
    bit          evt_coincide = 0, evt_spurious = 0, evt_force = 0;
    // Process-private state
    int          g_wait = 0;
    bit          g_was_req = 0, g_last_gnt = 0;
    int          e_cnt = 0;
    bit          e_armed = 0;
    bit          m_prev_req = 0, m_prev_gnt = 0, m_cont = 0;
    logic [7:0]  m_prev_addr = '0;
    logic [31:0] m_prev_data = '0;
    int          m_hold = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Job-level reference: a zero-size job yields one error event; any other
    // job yields its six register writes and one completion.
    function automatic void model_push(input job_s j);
        if (j.m == 0 || j.n == 0 || j.k == 0) begin
            exp_ev.push_back(EV_E);
            return;
        end
        exp_w.push_back({8'h00, j.x});
        exp_w.push_back({8'h04, j.w});
        exp_w.push_back({8'h08, j.z});
        exp_w.push_back({8'h0C, j.k, j.m});
        exp_w.push_back({8'h10, 16'h0000, j.n});
        exp_w.push_back({8'h20, 32'h1});
        exp_ev.push_back(EV_D);
        exp_cnt = exp_cnt + 16'd1;
    endfunction

    function automatic job_s rand_job(input bit allow_zero);
        job_s j;
        j.x = $urandom; j.w = $urandom; j.z = $urandom;
        j.m = 16'($urandom_range(1, 65535));
        j.n = 16'($urandom_range(1, 65535));
        j.k = 16'($urandom_range(1, 65535));
        if (allow_zero && $urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
                0:       j.m = '0;
                1:       j.n = '0;
                default: j.k = '0;
            endcase
        end
        return j;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        exp_w.delete(); exp_ev.delete(); obs_w.delete(); obs_ev.delete();
        exp_cnt = '0; stab_viol = 0; first_req_cyc = -1; last_done_cyc = -1;
        trig_seen = 0; trig_handled = 0; e_armed = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        job_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        clear_model();
        step(1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(job_ready), 64'd1);
        chk({tag, "_req"},   64'(cfg_req),   64'd0);
        chk({tag, "_addr"},  64'(cfg_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(cfg_wdata), 64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_err"},   64'(err),       64'd0);
        chk({tag, "_cnt"},   64'(done_cnt),  64'd0);
    endtask

    task automatic push_job(input job_s j);
        bit acc;
        acc = 1'b0;
        job_valid = 1'b1;
        job_x = j.x; job_w = j.w; job_z = j.z;
        job_m = j.m; job_n = j.n; job_k = j.k;
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = job_ready;
            @(posedge clk);
            #1;
        end
        job_valid = 1'b0;
        chk("push_accept", 64'(acc), 64'd1);
        if (acc) model_push(j);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((obs_ev.size() < exp_ev.size() || busy) && t < 3000) begin
            step(1);
            t++;
        end
        chk({tag, "_drain"}, 64'(t < 3000), 64'd1);
        step(3);
    endtask

    task automatic compare_all(input string tag, input int exp_hold);
        chk({tag, "_nwr"}, 64'(obs_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            chk({tag, "_wr"}, {24'h0, obs_w[i].addr, obs_w[i].data}, {24'h0, exp_w[i]});
            if (exp_hold > 0) chk({tag, "_hold"}, 64'(obs_w[i].hold), 64'(exp_hold));
        end
        chk({tag, "_nev"}, 64'(obs_ev.size()), 64'(exp_ev.size()));
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            chk({tag, "_ev"}, 64'(obs_ev[i]), 64'(exp_ev[i]));
        end
        chk({tag, "_stable"}, 64'(stab_viol), 64'd0);
        chk({tag, "_cnt"}, 64'(done_cnt), 64'(exp_cnt));
        exp_w.delete(); exp_ev.delete(); obs_w.delete(); obs_ev.delete();
        stab_viol = 0;
    endtask

    // Grant responder: always, after a fixed wait per write, or random.
    initial forever begin
        @(posedge clk);
        #1;
        if (!cfg_req || g_last_gnt || !g_was_req) g_wait = 0;
        else g_wait++;
        case (gnt_mode)
            0:       cfg_gnt = 1'b1;
            1:       cfg_gnt = cfg_req && (g_wait == gnt_delay);
            default: cfg_gnt = 1'($urandom_range(0, 1));
        endcase
        g_was_req  = cfg_req;
        g_last_gnt = cfg_gnt;
    end

    // Accelerator model: end-of-job event evt_delay cycles into BUSY, plus
    // optional events at moments where they must be ignored.
    initial forever begin
        @(posedge clk);
        #2;
        evt = 1'b0;
        if (evt_force) evt = 1'b1;
        if (evt_spurious && (!busy || cfg_req) && $urandom_range(0, 3) == 0) evt = 1'b1;
        if (evt_coincide && cfg_req && cfg_addr == 8'h20 && cfg_gnt) evt = 1'b1;
        if (trig_seen > trig_handled) begin
            trig_handled = trig_seen;
            e_cnt = evt_delay;
            e_armed = 1'b1;
        end
        if (e_armed) begin
            if (e_cnt == 0) begin
                evt = 1'b1;
                e_armed = 1'b0;
            end else begin
                e_cnt--;
            end
        end
    end

    // Monitor: records granted writes with their hold time, pulses, and any
    // change of a pending write before its grant.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            m_prev_req = 1'b0;
            m_prev_gnt = 1'b0;
        end else begin
            m_cont = m_prev_req && !m_prev_gnt;
            if (cfg_req) begin
                if (m_cont && (cfg_addr !== m_prev_addr || cfg_wdata !== m_prev_data)) stab_viol++;
                m_hold = m_cont ? m_hold + 1 : 1;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (cfg_gnt) begin
                    obs_w.push_back('{cfg_addr, cfg_wdata, m_hold});
                    if (cfg_addr == 8'h20) trig_seen++;
                end
            end else if (m_cont) begin
                stab_viol++;
            end
            if (done) begin
                obs_ev.push_back(EV_D);
                last_done_cyc = cyc;
            end
            if (err) obs_ev.push_back(EV_E);
            m_prev_req  = cfg_req;
            m_prev_gnt  = cfg_gnt;
            m_prev_addr = cfg_addr;
            m_prev_data = cfg_wdata;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        job_s j;
        int   t;
        #1;
        check_reset_vals("rst_init");

        // Single reference job, grant tied high, event 10 cycles after trigger
        do_reset();
        gnt_mode = 0; evt_delay = 9; evt_coincide = 0; evt_spurious = 0;
        j = '{32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd8, 16'd16};
        push_job(j);
        drain("single");
        if (obs_w.size() > 3) chk("single_wr3", {24'h0, obs_w[3].addr, obs_w[3].data}, 64'h0C_0010_0004);
        chk("single_latency", 64'(last_done_cyc - first_req_cyc), 64'(7 + evt_delay));
        chk("single_cnt1", 64'(done_cnt), 64'd1);
        compare_all("single", 0);

        // Grant delayed 3 cycles on every write
        do_reset();
        gnt_mode = 1; gnt_delay = 3; evt_delay = 2;
        push_job(rand_job(1'b0));
        drain("gdelay");
        compare_all("gdelay", 4);

        // Fill the queue while the first job is in BUSY
        do_reset();
        gnt_mode = 0; evt_delay = 40;
        push_job(rand_job(1'b0));
        t = 0;
        while (trig_seen < 1 && t < 100) begin
            step(1);
            t++;
        end
        chk("queue_trig_wait", 64'(t < 100), 64'd1);
        for (int i = 0; i < 4; i++) begin
            push_job(rand_job(1'b0));
            if (i == 2) chk("queue_ready_3", 64'(job_ready), 64'd1);
        end
        chk("queue_ready_full", 64'(job_ready), 64'd0);
        evt_delay = 3;
        drain("queue");
        chk("queue_cnt5", 64'(done_cnt), 64'd5);
        compare_all("queue", 0);

        // Zero-size job between two valid jobs, random grants
        do_reset();
        gnt_mode = 2; evt_delay = 1;
        push_job(rand_job(1'b0));
        j = rand_job(1'b0);
        j.k = '0;
        push_job(j);
        push_job(rand_job(1'b0));
        drain("zerok");
        chk("zerok_nwr", 64'(obs_w.size()), 64'd12);
        chk("zerok_cnt2", 64'(done_cnt), 64'd2);
        compare_all("zerok", 0);

        // Reset during PROG after two grants
        do_reset();
        gnt_mode = 0; evt_delay = 5;
        push_job(rand_job(1'b0));
        push_job(rand_job(1'b0));
        t = 0;
        while (obs_w.size() < 2 && t < 50) begin
            step(1);
            t++;
        end
        chk("rstmid_two_grants", 64'(obs_w.size()), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rstmid");
        step(2);
        rst_n = 1'b1;
        clear_model();
        evt_force = 1'b1;
        step(1);
        evt_force = 1'b0;
        evt_spurious = 1'b1;
        step(25);
        evt_spurious = 1'b0;
        chk("rstmid_nwr", 64'(obs_w.size()), 64'd0);
        chk("rstmid_nev", 64'(obs_ev.size()), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_cnt", 64'(done_cnt), 64'd0);

        // Randomized job streams under varied grant/event behaviour
        for (int r = 0; r < 4; r++) begin
            do_reset();
            gnt_mode     = $urandom_range(0, 2);
            gnt_delay    = $urandom_range(0, 2);
            evt_delay    = $urandom_range(0, 4);
            evt_coincide = 1'($urandom_range(0, 1));
            evt_spurious = 1'b1;
            for (int i = 0; i < 8; i++) begin
                push_job(rand_job(1'b1));
                step($urandom_range(0, 3));
            end
            drain("rand");
            compare_all("rand", 0);
        end
        evt_spurious = 1'b0;
        evt_coincide = 1'b0;

        // Counter wrap: preload the count of 65535 completions
        do_reset();
        gnt_mode = 0; evt_delay = 0;
        dut.done_cnt = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        push_job(rand_job(1'b0));
        drain("wrap");
        chk("wrap_cnt0", 64'(done_cnt), 64'd0);
        compare_all("wrap", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/redmule_job_dispatcher.md
REDMULE_JOB_DISPATCHER -- requirements
Module: redmule_job_dispatcher

Interface
REQ-001: Parameter DEPTH, default 4, job queue entries (power of two, >=2).
REQ-002: Parameter ADDR_W, default 32, descriptor address width.
REQ-003: clk_i  in  1  single clock; all state on rising edge.
REQ-004: rst_ni  in  1  asynchronous active-low reset.
REQ-005: job_valid_i  in  1  descriptor push request.
REQ-006: job_ready_o  out  1  queue can accept (not full).
REQ-007: job_x_i, job_w_i, job_z_i  in  ADDR_W each  X, W, Z base addresses.
REQ-008: job_m_i, job_n_i, job_k_i  in  16 each  matrix dimensions.
REQ-009: cfg_req_o  out  1  accelerator register-write request.
REQ-010: cfg_gnt_i  in  1  write accepted this cycle.
REQ-011: cfg_addr_o  out  8  register byte offset.
REQ-012: cfg_wdata_o  out  32  register write data.
REQ-013: evt_i  in  1  accelerator end-of-job event pulse.
REQ-014: busy_o  out  1  job in flight (state not IDLE).
REQ-015: done_o  out  1  one-cycle pulse per completed job.
REQ-016: err_o  out  1  one-cycle pulse per discarded zero-size job.
REQ-017: done_cnt_o  out  16  completed-job counter.

Function
REQ-018: Queue: FIFO of DEPTH descriptors; push on job_valid_i && job_ready_o; job_ready_o = !full.
REQ-019: Simultaneous push and pop when full: job_ready_o stays 0 that cycle, push not accepted; when empty, pop not possible, push lands and is popped no earlier than next cycle.
REQ-020: FSM states IDLE, PROG, TRIG, BUSY, DONE.
REQ-021: IDLE: if queue non-empty, pop head into working register; if any of m, n, k is 0, pulse err_o next cycle, stay IDLE; else go PROG.
REQ-022: PROG: issue 5 writes in order, one outstanding: 0x00 X, 0x04 W, 0x08 Z, 0x0C {k[15:0], m[15:0]}, 0x10 {16'h0, n[15:0]}.
REQ-023: cfg_req_o, cfg_addr_o, cfg_wdata_o held stable until cfg_gnt_i; next write presented the cycle after grant; no gap beyond that.
REQ-024: After grant of 0x10, go TRIG: write 0x20 data 32'h1; on grant go BUSY.
REQ-025: BUSY: wait for evt_i; go DONE.
REQ-026: DONE: done_o=1 for exactly this cycle, done_cnt_o increments (wraps 0xFFFF->0x0000), return IDLE.
REQ-027: evt_i outside BUSY ignored; evt_i coinciding with entry to BUSY (same cycle as trigger grant) ignored.
REQ-028: cfg_gnt_i while cfg_req_o=0 ignored.
REQ-029: Pushes accepted in every state; queue order preserved.
REQ-030: busy_o=1 in PROG, TRIG, BUSY, DONE.
REQ-031: Minimum job latency with cfg_gnt_i tied 1: pop to done_o = 1 (IDLE) + 5 (PROG) + 1 (TRIG) + BUSY wait + 1 cycles.

Reset
REQ-032: rst_ni low asynchronously forces IDLE, empties queue, clears working register.
REQ-033: Reset values: job_ready_o=1, cfg_req_o=0, cfg_addr_o=0, cfg_wdata_o=0, busy_o=0, done_o=0, err_o=0, done_cnt_o=0.
REQ-034: Reset mid-job abandons the job without done_o; no write issued after reset release until a new push.

Verification
REQ-035: Single job X=0x1000, W=0x2000, Z=0x3000, m=4, n=8, k=16, gnt=1 -> writes (0x00,0x1000),(0x04,0x2000),(0x08,0x3000),(0x0C,0x00100004),(0x10,0x8),(0x20,0x1); evt_i 10 cycles later -> one done_o, done_cnt_o=1.
REQ-036: cfg_gnt_i delayed 3 cycles per write -> each address/data held 4 cycles, order unchanged, no dropped or duplicated write.
REQ-037: Push 5 jobs back-to-back with DEPTH=4 while first in BUSY -> job_ready_o=0 after 4 queued; all jobs complete in push order, done_cnt_o=5.
REQ-038: Job with k=0 between two valid jobs -> err_o pulses once, no cfg writes for it, done_cnt_o=2.
REQ-039: Assert rst_ni=0 during PROG after 2 grants -> outputs at reset values immediately; queued jobs lost; spurious evt_i after release -> no done_o.
REQ-040: done_cnt_o preloaded via 65535 completions -> next completion wraps to 0.
